// File: rtl/systolic_feeder.sv
// systolic_feeder: captures matrices A and B, preloads B rows onto north_o, then skews A onto west_o.
// Optional synchronous abort port is compiled in with `define SYSTOLIC_FEEDER_ABORT_EN.
module systolic_feeder #(
    parameter int N         = 4,
    parameter int NUM_BITS  = 8,
    parameter int DRAIN_CYC = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid_i,
    output logic                start_ready_o,
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    input  logic                abort_i,
`endif
    input  logic [NUM_BITS-1:0] a_i [N][N],
    input  logic [NUM_BITS-1:0] b_i [N][N],
    output logic [NUM_BITS-1:0] north_o [N],
    output logic [NUM_BITS-1:0] west_o [N],
    output logic                busy_o,
    output logic                done_o
);

    localparam int STREAM_LEN = 2 * N - 1;
    localparam int MAX_CNT    = (DRAIN_CYC > STREAM_LEN) ? DRAIN_CYC : STREAM_LEN;
    localparam int CW         = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] LOAD_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_BITS-1:0] a_q [N][N];
    logic [NUM_BITS-1:0] a_d [N][N];
    logic [NUM_BITS-1:0] b_q [N][N];
    logic [NUM_BITS-1:0] b_d [N][N];
    logic [NUM_BITS-1:0] north_q [N];
    logic [NUM_BITS-1:0] north_d [N];
    logic [NUM_BITS-1:0] west_q [N];
    logic [NUM_BITS-1:0] west_d [N];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                abort_s;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    // Phase sequencing and operand capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (start_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_STREAM;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        // Abort only bites on an active job, so acceptance in IDLE always wins.
        if (abort_s && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            done_d  = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    // Output values for the cycle that follows the coming edge
    always_comb begin
        int step_s;
        step_s  = int'(cnt_d);
        north_d = '{default: {NUM_BITS{1'b0}}};
        west_d  = '{default: {NUM_BITS{1'b0}}};
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        if (state_d == ST_LOAD) begin
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    north_d[j] = north_d[j] | ((r == N - 1 - step_s) ? b_d[r][j] : {NUM_BITS{1'b0}});
                end
            end
        end else if (state_d == ST_STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int c = 0; c < N; c++) begin
                    west_d[i] = west_d[i] | ((c == step_s - i) ? a_d[i][c] : {NUM_BITS{1'b0}});
                end
            end
        end else begin
            north_d = '{default: {NUM_BITS{1'b0}}};
        end
    end

    // State, captured operands and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= '{default: {NUM_BITS{1'b0}}};
            b_q     <= '{default: {NUM_BITS{1'b0}}};
            north_q <= '{default: {NUM_BITS{1'b0}}};
            west_q  <= '{default: {NUM_BITS{1'b0}}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            north_q <= north_d;
            west_q  <= west_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign north_o       = north_q;
    assign west_o        = west_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign start_ready_o = ready_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, NUM_BITS=8, DRAIN_CYC=12); abort steps need SYSTOLIC_FEEDER_ABORT_EN.
module tb_systolic_feeder;

    localparam int N = 4;

    typedef logic [7:0] mat_t [4][4];

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic       busy;
    logic       done;
    mat_t       a_s;
    mat_t       b_s;
    logic [7:0] north_s [4];
    logic [7:0] west_s [4];
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    logic       abort_s;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    mat_t ea, eb, next_a, next_b, obs_a, obs_b;
    bit   use_id;
    logic [31:0] id_north [4];
    logic [31:0] id_west [7];

    wire [31:0] north_v = {north_s[3], north_s[2], north_s[1], north_s[0]};
    wire [31:0] west_v  = {west_s[3], west_s[2], west_s[1], west_s[0]};

    systolic_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
`ifdef SYSTOLIC_FEEDER_ABORT_EN
        .abort_i       (abort_s),
`endif
        .a_i           (a_s),
        .b_i           (b_s),
        .north_o       (north_s),
        .west_o        (west_s),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_pulses++;

    function automatic mat_t mk(input int kind);
        mat_t m;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (kind)
                    0:       m[i][j] = (i == j) ? 8'd1 : 8'd0;
                    1:       m[i][j] = 8'd1;
                    2:       m[i][j] = 8'(16 * i + j + 1);
                    3:       m[i][j] = 8'(128 + 4 * i + j);
                    4:       m[i][j] = 8'(200 - 7 * i - j);
                    5:       m[i][j] = 8'(3 * i + 5 * j + 1);
                    6:       m[i][j] = 8'h5a;
                    default: m[i][j] = 8'd0;
                endcase
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_north(input int k);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = eb[N-1-k][j];
        return r;
    endfunction

    function automatic logic [31:0] exp_west(input int t);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i < N) r[8*i +: 8] = ea[i][t-i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller leaves the bench in an IDLE cycle with start_valid high; returns in the done cycle.
    task automatic run_job(input bit keep_valid, input bit poke_busy, input bit ones_chk);
        int cyc;
        int c;
        obs_a = mk(7);
        obs_b = mk(7);
        step();
        cyc = 1;
        a_s = next_a;
        b_s = next_b;
        start_valid = keep_valid;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("load%0d_north", k), north_v, use_id ? id_north[k] : exp_north(k));
            chk($sformatf("load%0d_west", k), west_v, 32'h0);
            chk($sformatf("load%0d_busy", k), {31'h0, busy}, 32'h1);
            chk($sformatf("load%0d_ready", k), {31'h0, start_ready}, 32'h0);
            for (int j = 0; j < N; j++) obs_b[N-1-k][j] = north_s[j];
            step();
            cyc++;
        end
        for (int t = 0; t < 2 * N - 1; t++) begin
            chk($sformatf("stream%0d_west", t), west_v, use_id ? id_west[t] : exp_west(t));
            chk($sformatf("stream%0d_north", t), north_v, 32'h0);
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) obs_a[i][t-i] = west_s[i];
            end
            step();
            cyc++;
        end
        for (int d = 0; d < 12; d++) begin
            if (poke_busy && d == 3) begin
                start_valid = 1'b1;
                a_s = mk(6);
            end
            if (poke_busy && d == 4) begin
                start_valid = keep_valid;
                a_s = next_a;
            end
            chk($sformatf("drain%0d_out", d), north_v | west_v, 32'h0);
            chk($sformatf("drain%0d_done", d), {31'h0, done}, 32'h0);
            chk($sformatf("drain%0d_busy", d), {31'h0, busy}, 32'h1);
            step();
            cyc++;
        end
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("done_ready", {31'h0, start_ready}, 32'h1);
        chk("done_busy", {31'h0, busy}, 32'h0);
        chk("done_out", north_v | west_v, 32'h0);
        chk("latency", cyc, 32'd24);
        if (ones_chk) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    c = 0;
                    for (int k = 0; k < N; k++) c += int'(obs_a[i][k]) * int'(obs_b[k][j]);
                    chk($sformatf("ones_c%0d%0d", i, j), c, 32'd4);
                end
            end
        end
    endtask

    initial begin
        int p0;
        id_north = '{32'h0100_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0001};
        id_west  = '{32'h0000_0001, 32'h0, 32'h0000_0100, 32'h0, 32'h0001_0000, 32'h0, 32'h0100_0000};
        rst = 1'b1;
        start_valid = 1'b0;
        use_id = 1'b0;
        a_s = mk(7);
        b_s = mk(7);
`ifdef SYSTOLIC_FEEDER_ABORT_EN
        abort_s = 1'b0;
`endif
        step();
        step();
        chk("rst_out", north_v | west_v, 32'h0);
        chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
        rst = 1'b0;
        chk("rel_ready", {31'h0, start_ready}, 32'h1);
        step();
        chk("idle_ready", {31'h0, start_ready}, 32'h1);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Identity job, inputs changed right after acceptance
        ea = mk(0); eb = mk(0); a_s = mk(0); b_s = mk(0);
        next_a = mk(6); next_b = mk(6);
        use_id = 1'b1;
        start_valid = 1'b1;
        p0 = done_pulses;
        run_job(1'b0, 1'b0, 1'b0);
        use_id = 1'b0;
        step();
        chk("id_done_low", {31'h0, done}, 32'h0);
        chk("id_pulses", done_pulses - p0, 32'd1);

        // All-ones job
        ea = mk(1); eb = mk(1); a_s = mk(1); b_s = mk(1);
        next_a = mk(7); next_b = mk(7);
        start_valid = 1'b1;
        run_job(1'b0, 1'b0, 1'b1);
        step();

        // Back-to-back jobs with start_valid held high
        p0 = done_pulses;
        ea = mk(2); eb = mk(3); a_s = mk(2); b_s = mk(3);
        next_a = mk(4); next_b = mk(5);
        start_valid = 1'b1;
        run_job(1'b1, 1'b0, 1'b0);
        ea = mk(4); eb = mk(5);
        next_a = mk(7); next_b = mk(7);
        run_job(1'b0, 1'b0, 1'b0);
        step();
        chk("b2b_pulses", done_pulses - p0, 32'd2);

        // Request during DRAIN must be ignored
        ea = mk(2); eb = mk(3); a_s = mk(2); b_s = mk(3);
        next_a = mk(2); next_b = mk(3);
        start_valid = 1'b1;
        run_job(1'b0, 1'b1, 1'b0);
        step();
        chk("busy_rej_idle", {31'h0, busy}, 32'h0);

        // Reset at STREAM t=3
        p0 = done_pulses;
        ea = mk(2); eb = mk(3); a_s = mk(2); b_s = mk(3);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst_west", west_v, exp_west(3));
        rst = 1'b1;
        #1;
        chk("mid_rst_out", north_v | west_v, 32'h0);
        chk("mid_rst_busy_done", {30'h0, busy, done}, 32'h0);
        step();
        rst = 1'b0;
        chk("post_rst_ready", {31'h0, start_ready}, 32'h1);
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("post_rst%0d", i), {north_v | west_v} | {30'h0, busy, done}, 32'h0);
        end
        chk("rst_no_done", done_pulses - p0, 32'd0);

`ifdef SYSTOLIC_FEEDER_ABORT_EN
        // Abort at LOAD k=2, then a normal job
        p0 = done_pulses;
        ea = mk(4); eb = mk(5); a_s = mk(4); b_s = mk(5);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        chk("abort_k2_north", north_v, exp_north(2));
        abort_s = 1'b1;
        step();
        abort_s = 1'b0;
        chk("abort_out", north_v | west_v, 32'h0);
        chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
        chk("abort_ready", {31'h0, start_ready}, 32'h1);
        for (int i = 0; i < 25; i++) step();
        chk("abort_no_done", done_pulses - p0, 32'd0);
        ea = mk(2); eb = mk(3); a_s = mk(2); b_s = mk(3);
        next_a = mk(7); next_b = mk(7);
        start_valid = 1'b1;
        run_job(1'b0, 1'b0, 1'b0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (rows = columns).
REQ-002 SHALL have parameter NUM_BITS, default 8, element width.
REQ-003 SHALL have parameter DRAIN_CYC, default 12, idle cycles after streaming before completion; legal range is 1 or more.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_valid_i  input  1  job request; a_i and b_i are valid while it is high.
REQ-007 SHALL have port start_ready_o  output  1  feeder can accept a job.
REQ-008 SHALL have port a_i  input  [NUM_BITS-1:0] x [N][N]  matrix A, a_i[row][col].
REQ-009 SHALL have port b_i  input  [NUM_BITS-1:0] x [N][N]  matrix B (weights), b_i[row][col].
REQ-010 SHALL have port north_o  output  [NUM_BITS-1:0] x [N]  drives array north_i.
REQ-011 SHALL have port west_o  output  [NUM_BITS-1:0] x [N]  drives array west_i.
REQ-012 SHALL have port busy_o  output  1  high in LOAD, STREAM and DRAIN.
REQ-013 SHALL have port done_o  output  1  single-cycle completion pulse.

Function
REQ-014 SHALL implement a state machine with states IDLE, LOAD, STREAM and DRAIN.
REQ-015 SHALL set start_ready_o = 1 only in IDLE; acceptance = start_valid_i & start_ready_o at a rising edge.
REQ-016 SHALL, on acceptance, capture a_i and b_i into internal registers and move IDLE->LOAD; later input changes SHALL have no effect.
REQ-017 SHALL ignore start_valid_i outside IDLE; no queuing.
REQ-018 SHALL register all outputs; north_o and west_o SHALL be zero in IDLE and DRAIN.
REQ-019 SHALL hold LOAD for exactly N cycles, k = 0..N-1: north_o[j] = B[N-1-k][j]; west_o all zero.
REQ-020 SHALL run STREAM for exactly 2N-1 cycles, t = 0..2N-2: west_o[i] = A[i][t-i] when 0 <= t-i <= N-1, else 0; north_o all zero.
REQ-021 SHALL run DRAIN for exactly DRAIN_CYC cycles, then return to IDLE.
REQ-022 SHALL assert done_o for exactly one cycle: the first IDLE cycle after DRAIN; start_ready_o is also high in that cycle.
REQ-023 SHALL allow a job accepted in the done_o cycle; the next LOAD then follows with no gap.
REQ-024 SHALL keep the cycle counter wide enough for max(N, 2N-1, DRAIN_CYC) with no wrap inside a phase; the counter clears at every phase transition.
REQ-025 SHALL give a first-job latency from acceptance edge to done_o of N + 2N-1 + DRAIN_CYC + 1 cycles (24 for the defaults).

Reset
REQ-026 SHALL, while rst is high, immediately force IDLE, counter = 0, captured matrices = 0, and north_o, west_o, busy_o, done_o = 0.
REQ-027 SHALL make start_ready_o = 1 in the first cycle after rst deasserts.
REQ-028 SHALL treat reset during any phase as a clean abort: no done_o pulse and no partial stream output afterwards.

Configuration
REQ-029 SHALL support the macro SYSTOLIC_FEEDER_ABORT_EN.
REQ-030 SHALL, when SYSTOLIC_FEEDER_ABORT_EN is defined, add port abort_i (input, 1 bit, synchronous): in LOAD, STREAM or DRAIN it forces IDLE at the next edge with zero outputs and no done_o; in IDLE it has no effect; if abort_i and acceptance coincide, acceptance wins.
REQ-031 SHALL, when SYSTOLIC_FEEDER_ABORT_EN is undefined, have no abort_i port, and jobs always run to completion.

Verification
REQ-032 SHALL cover the identity case: N=4, A = B = I -> north_o[3], [2], [1], [0] = 1 in LOAD cycles 0..3; west_o[0], [1], [2], [3] = 1 at STREAM t = 0, 2, 4, 6; done_o exactly 24 cycles after acceptance.
REQ-033 SHALL cover the all-ones case: A = B = all 1 -> north_o = {1,1,1,1} for 4 cycles; west_o[i] = 1 for t in [i, i+3], else 0; checked against the array's C_o = 4 in every cell.
REQ-034 SHALL cover back-to-back jobs: start_valid_i held high across two jobs -> second acceptance in the done_o cycle; second LOAD starts on the next cycle; exactly two done_o pulses.
REQ-035 SHALL cover mid-stream reset: rst pulsed at STREAM t=3 -> all outputs 0 immediately; no done_o; start_ready_o = 1 in the first cycle after release.
REQ-036 SHALL cover busy rejection: start_valid_i with different A during DRAIN -> ignored; outputs and done_o timing unchanged.
REQ-037 SHALL cover abort (SYSTOLIC_FEEDER_ABORT_EN defined): abort_i at LOAD k=2 -> IDLE next cycle, north_o = 0, no done_o; a following job completes normally.
